// File: rtl/parity_selection_test_pkg.sv
// Shared fixed-point constants and width derivations for the parity selection pipeline.
package parity_selection_test_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < n; p = p << 1) begin
      r++;
    end
    return r;
  endfunction

  // Fixed-point 1.0 for the given number of fractional bits.
  function automatic int one_value(input int unsigned frac_w);
    return 1 << frac_w;
  endfunction

  // Fixed-point 0.5 for the given number of fractional bits.
  function automatic int half_value(input int unsigned frac_w);
    return (frac_w == 0) ? 0 : (1 << (frac_w - 1));
  endfunction

  // Signed width wide enough for the term sum plus the flip correction.
  function automatic int unsigned sum_width(input int unsigned data_w, input int unsigned blk_len);
    return data_w + clog2(blk_len) + 2;
  endfunction

  // Width of an element index; never below one bit.
  function automatic int unsigned idx_width(input int unsigned blk_len);
    return (clog2(blk_len) == 0) ? 1 : clog2(blk_len);
  endfunction

  // Number of surviving nodes after a given number of pairwise tree levels.
  function automatic int unsigned node_count(input int unsigned blk_len, input int unsigned lvl);
    return (blk_len + (1 << lvl) - 1) >> lvl;
  endfunction

endpackage

// File: rtl/parity_selection_test_pipeline_train.sv
// Valid/tag shift chain with a global stall: every stage advances together on enable.
module parity_selection_test_pipeline_train
  import parity_selection_test_pkg::*;
#(
  parameter int unsigned TAG_WIDTH = 32,
  parameter int unsigned STAGES    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_i,
  input  logic                 ready_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 enable_o,
  output logic                 valid_o,
  output logic [TAG_WIDTH-1:0] tag_o,
  output logic                 busy_o
);

  logic [STAGES-1:0]    valid_q;
  logic [TAG_WIDTH-1:0] tag_q [STAGES];

  // The pipe only stalls when the output holds data nobody is taking.
  assign enable_o = ready_i | ~valid_q[STAGES-1];
  assign valid_o  = valid_q[STAGES-1];
  assign tag_o    = tag_q[STAGES-1];
  assign busy_o   = |valid_q;

  // Shift valid bits and tags one stage per enabled cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int s = 0; s < int'(STAGES); s++) begin
        tag_q[s] <= '0;
      end
    end else if (enable_o) begin
      valid_q[0] <= valid_i;
      tag_q[0]   <= tag_i;
      for (int s = 1; s < int'(STAGES); s++) begin
        valid_q[s] <= valid_q[s-1];
        tag_q[s]   <= tag_q[s-1];
      end
    end
  end

endmodule

// File: rtl/parity_selection_test.sv
// Hard-decision selection with even-parity correction: picks the least reliable element
// (closest to HALF) and flips it when the hard decisions have even parity.
module parity_selection_test
  import parity_selection_test_pkg::*;
#(
  parameter int unsigned TAG_WIDTH      = 32,
  parameter int unsigned BLOCKLENGTH    = 6,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned FRACTION_WIDTH = 6
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  valid_in,
  input  logic                                                  ready_in,
  input  logic [TAG_WIDTH-1:0]                                  tag_in,
  input  logic [DATA_WIDTH*BLOCKLENGTH-1:0]                     data_in,
  output logic                                                  ready_out,
  output logic                                                  valid_out,
  output logic                                                  busy,
  output logic [TAG_WIDTH-1:0]                                  tag_out,
  output logic [BLOCKLENGTH-1:0]                                select_out,
  output logic [idx_width(BLOCKLENGTH)-1:0]                     flip_index,
  output logic                                                  flipped,
  output logic signed [sum_width(DATA_WIDTH, BLOCKLENGTH)-1:0]  sum_out,
  output logic                                                  indicator
);

  localparam int unsigned Levels = clog2(BLOCKLENGTH);
  localparam int unsigned Stages = 3 + Levels;
  localparam int unsigned SumW   = sum_width(DATA_WIDTH, BLOCKLENGTH);
  localparam int unsigned IdxW   = idx_width(BLOCKLENGTH);
  localparam logic signed [SumW-1:0] One  = SumW'(one_value(FRACTION_WIDTH));
  localparam logic signed [SumW-1:0] Half = SumW'(half_value(FRACTION_WIDTH));

  logic enable;

  parity_selection_test_pipeline_train #(
    .TAG_WIDTH (TAG_WIDTH),
    .STAGES    (Stages)
  ) u_train (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (valid_in),
    .ready_i  (ready_in),
    .tag_i    (tag_in),
    .enable_o (enable),
    .valid_o  (valid_out),
    .tag_o    (tag_out),
    .busy_o   (busy)
  );

  assign ready_out = enable;

  // Stage 0: input register.
  logic [DATA_WIDTH*BLOCKLENGTH-1:0] v_q;

  // Capture the raw block whenever the pipe advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
    end else if (enable) begin
      v_q <= data_in;
    end
  end

  // Tree level 0 is the classify/term stage; levels 1..Levels are the parallel
  // argmin and adder reductions. Each level carries the hard-decision vector along.
  logic signed [SumW-1:0] sum_d  [Levels+1][BLOCKLENGTH];
  logic signed [SumW-1:0] sum_q  [Levels+1][BLOCKLENGTH];
  logic        [SumW-1:0] dmin_d [Levels+1][BLOCKLENGTH];
  logic        [SumW-1:0] dmin_q [Levels+1][BLOCKLENGTH];
  logic        [IdxW-1:0] idx_d  [Levels+1][BLOCKLENGTH];
  logic        [IdxW-1:0] idx_q  [Levels+1][BLOCKLENGTH];
  logic [BLOCKLENGTH-1:0] f_d    [Levels+1];
  logic [BLOCKLENGTH-1:0] f_q    [Levels+1];

  for (genvar i = 0; i < int'(BLOCKLENGTH); i++) begin : g_leaf
    logic signed [SumW-1:0] v_ext;
    logic signed [SumW-1:0] diff;
    assign v_ext            = SumW'($signed(v_q[i*DATA_WIDTH +: DATA_WIDTH]));
    assign diff             = v_ext - Half;
    assign f_d[0][i]        = (v_ext >= Half);
    assign sum_d[0][i]      = f_d[0][i] ? (One - v_ext) : v_ext;
    assign dmin_d[0][i]     = diff[SumW-1] ? -diff : diff;
    assign idx_d[0][i]      = IdxW'(i);
  end

  for (genvar l = 1; l <= int'(Levels); l++) begin : g_level
    localparam int unsigned Prev = node_count(BLOCKLENGTH, l - 1);
    assign f_d[l] = f_q[l-1];
    for (genvar j = 0; j < int'(BLOCKLENGTH); j++) begin : g_node
      if (2 * j + 1 < int'(Prev)) begin : g_pair
        // Left child always covers lower indices, so '<=' keeps the lowest on ties.
        logic take_left;
        assign take_left    = dmin_q[l-1][2*j] <= dmin_q[l-1][2*j+1];
        assign dmin_d[l][j] = take_left ? dmin_q[l-1][2*j] : dmin_q[l-1][2*j+1];
        assign idx_d[l][j]  = take_left ? idx_q[l-1][2*j] : idx_q[l-1][2*j+1];
        assign sum_d[l][j]  = sum_q[l-1][2*j] + sum_q[l-1][2*j+1];
      end else if (2 * j < int'(Prev)) begin : g_pass
        assign dmin_d[l][j] = dmin_q[l-1][2*j];
        assign idx_d[l][j]  = idx_q[l-1][2*j];
        assign sum_d[l][j]  = sum_q[l-1][2*j];
      end else begin : g_zero
        assign dmin_d[l][j] = '0;
        assign idx_d[l][j]  = '0;
        assign sum_d[l][j]  = '0;
      end
    end
  end

  // Register the classify stage and every reduction level in lockstep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l <= int'(Levels); l++) begin
        f_q[l] <= '0;
        for (int j = 0; j < int'(BLOCKLENGTH); j++) begin
          sum_q[l][j]  <= '0;
          dmin_q[l][j] <= '0;
          idx_q[l][j]  <= '0;
        end
      end
    end else if (enable) begin
      for (int l = 0; l <= int'(Levels); l++) begin
        f_q[l] <= f_d[l];
        for (int j = 0; j < int'(BLOCKLENGTH); j++) begin
          sum_q[l][j]  <= sum_d[l][j];
          dmin_q[l][j] <= dmin_d[l][j];
          idx_q[l][j]  <= idx_d[l][j];
        end
      end
    end
  end

  // Final stage: parity check, conditional flip and threshold.
  logic [BLOCKLENGTH-1:0] sel_d, sel_q;
  logic                   flip_d, flip_q;
  logic [IdxW-1:0]        fidx_d, fidx_q;
  logic signed [SumW-1:0] delta, sumf_d, sumf_q;
  logic                   ind_d, ind_q;

  // Flip f_k on even parity. delta_k = f_k ? 2v_k-ONE : ONE-2v_k, which is exactly
  // 2*|v_k-HALF|, so the carried minimum distance doubles as the correction.
  always_comb begin
    flip_d = ~(^f_q[Levels]);
    fidx_d = idx_q[Levels][0];
    sel_d  = f_q[Levels];
    for (int i = 0; i < int'(BLOCKLENGTH); i++) begin
      if (flip_d && (fidx_d == IdxW'(i))) begin
        sel_d[i] = ~f_q[Levels][i];
      end
    end
    delta  = flip_d ? {dmin_q[Levels][0][SumW-2:0], 1'b0} : '0;
    sumf_d = sum_q[Levels][0] + delta;
    ind_d  = (sumf_d >= One);
  end

  // Output register, held while downstream stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q  <= '0;
      flip_q <= 1'b0;
      fidx_q <= '0;
      sumf_q <= '0;
      ind_q  <= 1'b0;
    end else if (enable) begin
      sel_q  <= sel_d;
      flip_q <= flip_d;
      fidx_q <= fidx_d;
      sumf_q <= sumf_d;
      ind_q  <= ind_d;
    end
  end

  assign select_out = sel_q;
  assign flipped    = flip_q;
  assign flip_index = fidx_q;
  assign sum_out    = sumf_q;
  assign indicator  = ind_q;

endmodule

// File: tb/tb_parity_selection_test.sv
// Directed-vector bench for parity_selection_test at BLOCKLENGTH=3 (latency 5).
module tb_parity_selection_test;

  localparam int unsigned TagW = 16;
  localparam int unsigned Bl   = 3;
  localparam int unsigned Dw   = 8;
  localparam int unsigned Fw   = 6;
  localparam int          NVec = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               valid_in;
  logic               ready_in;
  logic [TagW-1:0]    tag_in;
  logic [Dw*Bl-1:0]   data_in;
  logic               ready_out;
  logic               valid_out;
  logic               busy;
  logic [TagW-1:0]    tag_out;
  logic [Bl-1:0]      select_out;
  logic [1:0]         flip_index;
  logic               flipped;
  logic signed [11:0] sum_out;
  logic               indicator;

  always #5 clk = ~clk;

  parity_selection_test #(
    .TAG_WIDTH      (TagW),
    .BLOCKLENGTH    (Bl),
    .DATA_WIDTH     (Dw),
    .FRACTION_WIDTH (Fw)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .tag_in     (tag_in),
    .data_in    (data_in),
    .ready_out  (ready_out),
    .valid_out  (valid_out),
    .busy       (busy),
    .tag_out    (tag_out),
    .select_out (select_out),
    .flip_index (flip_index),
    .flipped    (flipped),
    .sum_out    (sum_out),
    .indicator  (indicator)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Element values (element 0 first) and hand-computed results.
  int va     [NVec] = '{48, 64, -32, -128, 127,  32, 30,  0};
  int vb     [NVec] = '{48,  0,  96, -128, 127,  31, 30, 31};
  int vc     [NVec] = '{16,  0,  32, -128, 127, 100, 40,  0};
  int e_sel  [NVec] = '{ 2,  1,   2,    1,   7,   4,  4,  2};
  int e_flip [NVec] = '{ 1,  0,   1,    1,   0,   1,  0,  1};
  int e_idx  [NVec] = '{ 0,  0,   2,    0,   0,   0,  0,  1};
  int e_sum  [NVec] = '{80,  0, -32,  -64,-189,  27, 84, 33};
  int e_ind  [NVec] = '{ 1,  0,   0,    0,   0,   0,  1,  0};

  task automatic check_eq(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic load_vec(input int v);
    data_in = {8'(vc[v]), 8'(vb[v]), 8'(va[v])};
  endtask

  // Drive ntx back-to-back transactions (vectors vec0, vec0+1, ...), optionally drop
  // ready_in for steps st_from..st_to, and check every valid output cycle.
  // Entered and left just after a rising edge.
  task automatic stream(input int ntx, input int base, input int vec0, input int st_from,
                        input int st_to, input int steps, output int first_v,
                        output int last_v, output int n_hs, output int n_valid);
    int k;
    first_v = -1;
    last_v  = -1;
    n_hs    = 0;
    n_valid = 0;
    for (int t = 0; t < steps; t++) begin
      valid_in = (t < ntx);
      tag_in   = TagW'(base + t);
      load_vec((vec0 + t) % NVec);
      ready_in = !(t >= st_from && t <= st_to);
      #1;
      if (valid_out) begin
        n_valid++;
        if (first_v < 0) first_v = t;
        last_v = t;
        if (n_hs < ntx) begin
          k = (vec0 + n_hs) % NVec;
          check_eq("tag_out", tag_out, base + n_hs);
          check_eq("select_out", select_out, e_sel[k]);
          check_eq("flipped", flipped, e_flip[k]);
          check_eq("flip_index", flip_index, e_idx[k]);
          check_eq("sum_out", $signed(sum_out), e_sum[k]);
          check_eq("indicator", indicator, e_ind[k]);
        end else begin
          check_eq("extra_out", valid_out, 0);
        end
        if (ready_in) n_hs++;
      end
      check_eq("ready_out", ready_out, (ready_in || !valid_out) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
  endtask

  initial begin
    int first_v, last_v, n_hs, n_valid, stale;
    reset    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    tag_in   = '0;
    data_in  = '0;
    #1 reset = 1'b1;
    #1;
    check_eq("rst_valid_out", valid_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready_out", ready_out, 1);
    check_eq("rst_select", select_out, 0);
    check_eq("rst_flipped", flipped, 0);
    check_eq("rst_flip_index", flip_index, 0);
    check_eq("rst_sum", $signed(sum_out), 0);
    check_eq("rst_indicator", indicator, 0);
    check_eq("rst_tag", tag_out, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single transactions through every directed vector.
    for (int v = 0; v < NVec; v++) begin
      stream(1, 10 + v, v, 100, 0, 8, first_v, last_v, n_hs, n_valid);
      check_eq("single_latency", first_v, 5);
      check_eq("single_count", n_hs, 1);
    end

    // Ten back-to-back transactions with ready_in held high.
    stream(10, 100, 0, 100, 0, 20, first_v, last_v, n_hs, n_valid);
    check_eq("b2b_first", first_v, 5);
    check_eq("b2b_last", last_v, 14);
    check_eq("b2b_valid_cycles", n_valid, 10);
    check_eq("b2b_handshakes", n_hs, 10);

    // Three in flight, ready_in low for six cycles.
    stream(3, 200, 2, 3, 8, 16, first_v, last_v, n_hs, n_valid);
    check_eq("stall_first", first_v, 5);
    check_eq("stall_valid_cycles", n_valid, 7);
    check_eq("stall_handshakes", n_hs, 3);
    check_eq("stall_busy_after", busy, 0);

    // Reset with four transactions in flight.
    for (int t = 0; t < 4; t++) begin
      valid_in = 1'b1;
      ready_in = 1'b1;
      tag_in   = TagW'(300 + t);
      load_vec(t);
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    check_eq("inflight_busy", busy, 1);
    check_eq("inflight_valid_out", valid_out, 0);
    reset = 1'b1;
    #1;
    check_eq("midrst_valid_out", valid_out, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_ready_out", ready_out, 1);
    check_eq("midrst_sum", $signed(sum_out), 0);
    check_eq("midrst_select", select_out, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    stale = 0;
    for (int t = 0; t < 10; t++) begin
      @(posedge clk);
      #1;
      if (valid_out) stale++;
    end
    check_eq("no_stale_output", stale, 0);
    check_eq("post_rst_busy", busy, 0);
    stream(1, 400, 2, 100, 0, 8, first_v, last_v, n_hs, n_valid);
    check_eq("post_rst_latency", first_v, 5);
    check_eq("post_rst_count", n_hs, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
